// File: rtl/ptw_pte_fetch_pkg.sv
// Shared MMU parameters and walk-sequencer state encoding for the Sv39 PTE fetch block.
package ptw_pte_fetch_pkg;

    localparam int unsigned PTE_SIZE_IN_BIT        = 64;
    localparam int unsigned PHYSICAL_ADDR_LEN_SV39 = 56;
    localparam int unsigned MEM_DATA_WIDTH         = 32;
    localparam int unsigned PTE_BYTES              = 8;
    localparam int unsigned BEAT_BYTES             = 4;
    localparam logic [1:0]  SV39_TOP_LEVEL         = 2'd2;

    typedef enum logic [3:0] {
        StIdle,
        StIssueLo,
        StWaitLo,
        StIssueHi,
        StWaitHi,
        StPteValid,
        StDrain,
        StDrainIssueLo,
        StDrainIssueHi
    } ptw_state_e;

endpackage

// File: rtl/ptw_pte_fetch_if.sv
// Memory read port between the PTE fetch block (master) and the D-side arbiter (slave).
interface ptw_pte_fetch_if;
    import ptw_pte_fetch_pkg::*;

    logic                              mem_req_valid;
    logic                              mem_req_ready;
    logic [PHYSICAL_ADDR_LEN_SV39-1:0] mem_req_addr;
    logic                              mem_resp_valid;
    logic [MEM_DATA_WIDTH-1:0]         mem_resp_data;
    logic                              mem_resp_error;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data,
        input  mem_resp_error
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data,
        output mem_resp_error
    );

endinterface

// File: rtl/ptw_pte_fetch.sv
// Sv39 walk sequencer: tracks the level and fetches each 64-bit PTE as two 32-bit beats,
// then acts on the combinational walker's leaf / fault / next-level decision.
module ptw_pte_fetch
    import ptw_pte_fetch_pkg::*;
(
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              walk_start_i,
    input  logic                              flush_i,
    input  logic                              req_next_level_pte_i,
    input  logic [PHYSICAL_ADDR_LEN_SV39-1:0] pte_req_address_i,
    input  logic                              pte_is_leaf_i,
    input  logic                              page_fault_valid_i,
    output logic [1:0]                        page_table_level_o,
    output logic                              pte_active_o,
    output logic [PTE_SIZE_IN_BIT-1:0]        pte_o,
    output logic                              walk_busy_o,
    output logic                              walk_done_o,
    output logic                              walk_page_fault_o,
    output logic                              walk_access_fault_o,
    ptw_pte_fetch_if.master                   mem
);

    ptw_state_e                        state_q, state_d;
    logic [1:0]                        level_q, level_d;
    logic [PHYSICAL_ADDR_LEN_SV39-1:0] addr_q, addr_d;
    logic [MEM_DATA_WIDTH-1:0]         pte_lo_q, pte_hi_q;
    logic                              lo_we, hi_we;
    logic                              done_q, done_d;
    logic                              pf_q, pf_d;
    logic                              af_q, af_d;
    logic                              hi_beat;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        addr_d  = addr_q;
        lo_we   = 1'b0;
        hi_we   = 1'b0;
        done_d  = 1'b0;
        pf_d    = 1'b0;
        af_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (walk_start_i && req_next_level_pte_i && !flush_i) begin
                    addr_d  = pte_req_address_i;
                    level_d = SV39_TOP_LEVEL;
                    state_d = StIssueLo;
                end
            end
            StIssueLo, StIssueHi: begin
                // A flushed request that is not yet accepted must still complete its handshake.
                if (flush_i) begin
                    if (mem.mem_req_ready)        state_d = StDrain;
                    else if (state_q == StIssueLo) state_d = StDrainIssueLo;
                    else                           state_d = StDrainIssueHi;
                end else if (mem.mem_req_ready) begin
                    state_d = (state_q == StIssueLo) ? StWaitLo : StWaitHi;
                end
            end
            StWaitLo, StWaitHi: begin
                if (flush_i) begin
                    // A beat arriving with the flush retires the only outstanding request.
                    state_d = mem.mem_resp_valid ? StIdle : StDrain;
                end else if (mem.mem_resp_valid) begin
                    if (mem.mem_resp_error) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        af_d    = 1'b1;
                    end else if (state_q == StWaitLo) begin
                        lo_we   = 1'b1;
                        state_d = StIssueHi;
                    end else begin
                        hi_we   = 1'b1;
                        state_d = StPteValid;
                    end
                end
            end
            StPteValid: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (page_fault_valid_i) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    pf_d    = 1'b1;
                end else if (pte_is_leaf_i) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else if (req_next_level_pte_i) begin
                    addr_d  = pte_req_address_i;
                    level_d = level_q - 2'd1;
                    state_d = StIssueLo;
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    pf_d    = 1'b1;
                end
            end
            StDrainIssueLo, StDrainIssueHi: begin
                if (mem.mem_req_ready) state_d = StDrain;
            end
            StDrain: begin
                if (mem.mem_resp_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            level_q  <= SV39_TOP_LEVEL;
            addr_q   <= '0;
            pte_lo_q <= '0;
            pte_hi_q <= '0;
            done_q   <= 1'b0;
            pf_q     <= 1'b0;
            af_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            pf_q    <= pf_d;
            af_q    <= af_d;
            if (lo_we) pte_lo_q <= mem.mem_resp_data;
            if (hi_we) pte_hi_q <= mem.mem_resp_data;
        end
    end

    always_comb begin
        hi_beat           = (state_q == StIssueHi) || (state_q == StDrainIssueHi);
        mem.mem_req_valid = (state_q == StIssueLo) || (state_q == StDrainIssueLo) || hi_beat;
        mem.mem_req_addr  = hi_beat ? addr_q + PHYSICAL_ADDR_LEN_SV39'(BEAT_BYTES) : addr_q;
        pte_active_o      = (state_q == StPteValid);
        walk_busy_o       = (state_q != StIdle);
        // Level underflow to 2'b11 is intentional: the walker faults on it.
        if (state_q == StIdle)          page_table_level_o = SV39_TOP_LEVEL;
        else if (state_q == StPteValid) page_table_level_o = level_q - 2'd1;
        else                            page_table_level_o = level_q;
    end

    assign pte_o               = {pte_hi_q, pte_lo_q};
    assign walk_done_o         = done_q;
    assign walk_page_fault_o   = pf_q;
    assign walk_access_fault_o = af_q;

endmodule
